// File: rtl/traffic_light_ctrl_param_pkg.sv
// ============================================================================
// Module  : traffic_light_ctrl_param_pkg
// Brief   : Phase encoding, lamp record and lamp decode shared by the traffic
//           light controller and anything that monitors its phase output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_light_ctrl_param_pkg;

    localparam int PHASE_W = 3;

    // Code 7 is unused; the controller treats it as a corrupted state.
    typedef enum logic [PHASE_W-1:0] {
        GREEN_A   = 3'd0,
        AMBER_A   = 3'd1,
        ALLRED_AB = 3'd2,
        GREEN_B   = 3'd3,
        AMBER_B   = 3'd4,
        ALLRED_BA = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    typedef struct packed {
        logic ra;
        logic oa;
        logic ga;
        logic rb;
        logic ob;
        logic gb;
    } lamps_t;

    // Lamp pattern for a phase; unknown codes show all-red.
    function automatic lamps_t lamp_decode(input phase_e ph, input logic blink);
        lamps_t l;
        l = '0;
        case (ph)
            GREEN_A: begin l.ga = 1'b1; l.rb = 1'b1; end
            AMBER_A: begin l.oa = 1'b1; l.rb = 1'b1; end
            GREEN_B: begin l.gb = 1'b1; l.ra = 1'b1; end
            AMBER_B: begin l.ob = 1'b1; l.ra = 1'b1; end
            FLASH:   begin l.oa = blink; l.ob = blink; end
            default: begin l.ra = 1'b1; l.rb = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_ctrl_param_phase_timer.sv
// ============================================================================
// Module  : traffic_light_ctrl_param_phase_timer
// Brief   : Phase timer. Cleared by clr, otherwise counts up once per cycle
//           and saturates at all-ones so "at or after expiry" tests stay true
//           through arbitrarily long holds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl_param_phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_q;

    // Count cycles spent in the current phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (count_q != {TW{1'b1}}) begin
            count_q <= count_q + TW'(1);
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl_param.sv
// ============================================================================
// Module  : traffic_light_ctrl_param
// Brief   : Two-approach traffic light controller with programmable phase
//           durations, all-red clearance, latched side-road request,
//           demand-extended side green and night flashing-amber mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl_param
    import traffic_light_ctrl_param_pkg::*;
#(
    parameter int TW            = 8,
    parameter int T_GREEN_A     = 60,
    parameter int T_AMBER       = 10,
    parameter int T_ALLRED      = 2,
    parameter int T_GREEN_B_MIN = 20,
    parameter int T_GREEN_B_MAX = 40,
    parameter int FLASH_HALF    = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensorB,
    input  logic               night,
    output logic               RA,
    output logic               OA,
    output logic               GA,
    output logic               RB,
    output logic               OB,
    output logic               GB,
    output logic [PHASE_W-1:0] phase
);

    localparam int C_TMAX = (1 << TW) - 1;

    // Reject durations that are zero, do not fit the timer, or invert min/max.
    if (T_GREEN_A < 1 || T_AMBER < 1 || T_ALLRED < 1 || T_GREEN_B_MIN < 1 ||
        T_GREEN_B_MAX < 1 || FLASH_HALF < 1) begin : g_chk_nonzero
        $error("traffic_light_ctrl_param: every duration must be nonzero");
    end
    if (T_GREEN_A > C_TMAX || T_AMBER > C_TMAX || T_ALLRED > C_TMAX ||
        T_GREEN_B_MIN > C_TMAX || T_GREEN_B_MAX > C_TMAX || FLASH_HALF > C_TMAX) begin : g_chk_width
        $error("traffic_light_ctrl_param: a duration does not fit in TW bits");
    end
    if (T_GREEN_B_MAX < T_GREEN_B_MIN) begin : g_chk_minmax
        $error("traffic_light_ctrl_param: T_GREEN_B_MAX must be >= T_GREEN_B_MIN");
    end

    // Timer value on the last cycle of each duration.
    localparam logic [TW-1:0] C_GA_LAST    = TW'(T_GREEN_A - 1);
    localparam logic [TW-1:0] C_AMB_LAST   = TW'(T_AMBER - 1);
    localparam logic [TW-1:0] C_AR_LAST    = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] C_GBMIN_LAST = TW'(T_GREEN_B_MIN - 1);
    localparam logic [TW-1:0] C_GBMAX_LAST = TW'(T_GREEN_B_MAX - 1);
    localparam logic [TW-1:0] C_FH_LAST    = TW'(FLASH_HALF - 1);

    phase_e        state_q, state_d;
    logic          req_b_q, req_b_d;
    logic          flash_q, flash_d;
    logic          blink_q, blink_d;
    lamps_t        lamps_q, lamps_d;
    logic [TW-1:0] timer;
    logic          timer_clr;

    traffic_light_ctrl_param_phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .count(timer)
    );

    // Next-state, request latch, blink and lamp decode.
    always_comb begin
        state_d   = state_q;
        flash_d   = flash_q;
        blink_d   = blink_q;
        timer_clr = 1'b0;

        case (state_q)
            GREEN_A: begin
                if (timer >= C_GA_LAST) begin
                    if (night) begin
                        state_d = AMBER_A;
                        flash_d = 1'b1;
                    end else if (req_b_q) begin
                        state_d = AMBER_A;
                        flash_d = 1'b0;
                    end
                end
            end
            AMBER_A:   if (timer == C_AMB_LAST) state_d = ALLRED_AB;
            ALLRED_AB: if (timer == C_AR_LAST)  state_d = flash_q ? FLASH : GREEN_B;
            GREEN_B: begin
                if (timer == C_GBMAX_LAST || (timer >= C_GBMIN_LAST && !sensorB))
                    state_d = AMBER_B;
            end
            AMBER_B:   if (timer == C_AMB_LAST) state_d = ALLRED_BA;
            ALLRED_BA: if (timer == C_AR_LAST)  state_d = GREEN_A;
            FLASH: begin
                if (!night) begin
                    state_d = ALLRED_BA;
                    flash_d = 1'b0;
                end else if (timer == C_FH_LAST) begin
                    // Half-period done: flip the lamps and start the next half.
                    blink_d   = ~blink_q;
                    timer_clr = 1'b1;
                end
            end
            default:   state_d = ALLRED_BA;
        endcase

        if (state_d != state_q) timer_clr = 1'b1;
        if (state_d == FLASH && state_q != FLASH) blink_d = 1'b1;

        // Entering GREEN_B serves the request, so the clear takes priority.
        req_b_d = req_b_q;
        if (sensorB && state_q != GREEN_B) req_b_d = 1'b1;
        if (state_d == GREEN_B && state_q != GREEN_B) req_b_d = 1'b0;

        lamps_d = lamp_decode(state_d, blink_d);
    end

    // Controller state and lamp registers; lamps change on the same edge as phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ALLRED_BA;
            req_b_q <= 1'b0;
            flash_q <= 1'b0;
            blink_q <= 1'b1;
            lamps_q <= lamp_decode(ALLRED_BA, 1'b1);
        end else begin
            state_q <= state_d;
            req_b_q <= req_b_d;
            flash_q <= flash_d;
            blink_q <= blink_d;
            lamps_q <= lamps_d;
        end
    end

    assign RA    = lamps_q.ra;
    assign OA    = lamps_q.oa;
    assign GA    = lamps_q.ga;
    assign RB    = lamps_q.rb;
    assign OB    = lamps_q.ob;
    assign GB    = lamps_q.gb;
    assign phase = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
// ============================================================================
// Module  : tb_traffic_light_ctrl_param
// Brief   : Self-checking bench for traffic_light_ctrl_param with short
//           durations: per-edge vector table plus reset and safety checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl_param;
    import traffic_light_ctrl_param_pkg::*;

    // Lamp words ordered {RA,OA,GA,RB,OB,GB}.
    localparam logic [5:0] L_GA = 6'b001_100;
    localparam logic [5:0] L_OA = 6'b010_100;
    localparam logic [5:0] L_RR = 6'b100_100;
    localparam logic [5:0] L_GB = 6'b100_001;
    localparam logic [5:0] L_OB = 6'b100_010;
    localparam logic [5:0] L_F1 = 6'b010_010;
    localparam logic [5:0] L_F0 = 6'b000_000;

    logic       clk;
    logic       reset;
    logic       sensorB;
    logic       night;
    logic       RA, OA, GA, RB, OB, GB;
    logic [2:0] phase;

    int checks;
    int errors;

    typedef struct {
        logic       s;
        logic       n;
        phase_e     ph;
        logic [5:0] lamps;
    } vec_t;

    vec_t vecs[$];

    traffic_light_ctrl_param #(
        .TW           (8),
        .T_GREEN_A    (6),
        .T_AMBER      (2),
        .T_ALLRED     (1),
        .T_GREEN_B_MIN(3),
        .T_GREEN_B_MAX(5),
        .FLASH_HALF   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sensorB(sensorB),
        .night  (night),
        .RA     (RA),
        .OA     (OA),
        .GA     (GA),
        .RB     (RB),
        .OB     (OB),
        .GB     (GB),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic n, input phase_e ph,
                       input logic [5:0] l, input int reps);
        for (int k = 0; k < reps; k++) vecs.push_back('{s, n, ph, l});
    endtask

    task automatic check_out(input string name, input phase_e ph, input logic [5:0] l);
        checks++;
        if (phase !== 3'(ph)) begin
            errors++;
            $display("FAIL %s phase got %0d want %0d", name, phase, ph);
        end
        checks++;
        if ({RA, OA, GA, RB, OB, GB} !== l) begin
            errors++;
            $display("FAIL %s lamps got %b want %b", name, {RA, OA, GA, RB, OB, GB}, l);
        end
    endtask

    // Safety invariant and legal phase code, every cycle out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((((GA | OA) & (GB | OB)) === 1'b1 && phase != 3'(FLASH)) || phase > 3'd6) begin
                errors++;
                $display("FAIL safety phase=%0d lamps=%b", phase, {RA, OA, GA, RB, OB, GB});
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        sensorB = 1'b0;
        night   = 1'b0;

        // Sensor pulse in GREEN_A timer cycle 2, then a full B cycle.
        add(0, 0, GREEN_A,   L_GA, 3);
        add(1, 0, GREEN_A,   L_GA, 1);
        add(0, 0, GREEN_A,   L_GA, 2);
        add(0, 0, AMBER_A,   L_OA, 2);
        add(0, 0, ALLRED_AB, L_RR, 1);
        add(0, 0, GREEN_B,   L_GB, 3);
        add(0, 0, AMBER_B,   L_OB, 2);
        add(0, 0, ALLRED_BA, L_RR, 1);
        // No demand: GREEN_A held well past its minimum.
        add(0, 0, GREEN_A,   L_GA, 13);
        // Sensor held: max-green cap, request re-latched in AMBER_B.
        add(1, 0, GREEN_A,   L_GA, 1);
        add(1, 0, AMBER_A,   L_OA, 2);
        add(1, 0, ALLRED_AB, L_RR, 1);
        add(1, 0, GREEN_B,   L_GB, 5);
        add(1, 0, AMBER_B,   L_OB, 2);
        add(0, 0, ALLRED_BA, L_RR, 1);
        add(0, 0, GREEN_A,   L_GA, 6);
        add(0, 0, AMBER_A,   L_OA, 2);
        add(0, 0, ALLRED_AB, L_RR, 1);
        add(0, 0, GREEN_B,   L_GB, 3);
        add(0, 0, AMBER_B,   L_OB, 2);
        add(0, 0, ALLRED_BA, L_RR, 1);
        add(0, 0, GREEN_A,   L_GA, 1);
        // Request plus night at GREEN_A expiry: night wins, then flashing.
        add(1, 0, GREEN_A,   L_GA, 1);
        add(0, 1, GREEN_A,   L_GA, 4);
        add(0, 1, AMBER_A,   L_OA, 2);
        add(0, 1, ALLRED_AB, L_RR, 1);
        add(0, 1, FLASH,     L_F1, 2);
        add(0, 1, FLASH,     L_F0, 2);
        add(0, 1, FLASH,     L_F1, 2);
        // Night dropped: back to A, latched request then served.
        add(0, 0, ALLRED_BA, L_RR, 1);
        add(0, 0, GREEN_A,   L_GA, 6);
        add(0, 0, AMBER_A,   L_OA, 2);
        add(0, 0, ALLRED_AB, L_RR, 1);
        add(0, 0, GREEN_B,   L_GB, 2);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_out("reset", ALLRED_BA, L_RR);
        reset = 1'b1;

        foreach (vecs[i]) begin
            sensorB = vecs[i].s;
            night   = vecs[i].n;
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("vec[%0d]", i), vecs[i].ph, vecs[i].lamps);
        end

        // Asynchronous reset in mid GREEN_B, observed before any clock edge.
        sensorB = 1'b0;
        night   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", ALLRED_BA, L_RR);
        @(posedge clk);
        @(negedge clk);
        check_out("reset_held", ALLRED_BA, L_RR);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("post_reset_allred", GREEN_A, L_GA);
        // No stale request: GREEN_A must outlast its minimum.
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("post_reset_hold[%0d]", k), GREEN_A, L_GA);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
